// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the gated edge-counting frequency meter.
package freq_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int unsigned DEF_CLK_HZ      = 50_000_000;
    localparam int unsigned DEF_GATE_CYCLES = 50_000_000;
    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned SETTLE_CYCLES   = DEF_SYNC_STAGES + 1;

    // Cycles to wait after reset so a high input at reset cannot fake an edge.
    function automatic int unsigned settle_cycles(input int unsigned sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/freq_meter_sig_sync_edge.sv
// Synchronizes the asynchronous measured signal and flags its rising edges.
module sig_sync_edge
    import freq_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic RESETn,
    input  logic sig_in,
    output logic sync_out,
    output logic edge_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_c   = sync_out & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over back-to-back gate windows of GATE_CYCLES clocks.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             RESETn,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned GATE_W   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned SETTLE_N = settle_cycles(SYNC_STAGES);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_N + 1);
    localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SETTLE_N);

    if (GATE_CYCLES < 2 || SYNC_STAGES < 2 || CLK_HZ == 0) begin : g_bad_param
        $error("freq_meter: invalid parameter set");
    end

    state_t              state;
    state_t              state_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [GATE_W-1:0]   gate_cnt;
    logic [CNT_W-1:0]    edge_cnt;
    logic                ovf;

    logic                edge_c;
    logic                sync_unused;
    logic                settled_c;
    logic                window_end_c;
    logic                run_c;
    logic                cnt_max_c;
    logic                sat_edge_c;
    logic [CNT_W-1:0]    edge_cnt_inc_c;

    sig_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .RESETn  (RESETn),
        .sig_in  (sig_in),
        .sync_out(sync_unused),
        .edge_c  (edge_c)
    );

    assign settled_c      = (settle_cnt == SETTLE_DONE);
    assign cnt_max_c      = &edge_cnt;
    assign sat_edge_c     = edge_c & cnt_max_c;
    assign edge_cnt_inc_c = edge_cnt + CNT_W'(edge_c & ~cnt_max_c);

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle counter control.
    always_comb begin
        state_nxt    = state;
        window_end_c = 1'b0;
        run_c        = 1'b0;
        case (state)
            IDLE: begin
                if (settled_c && enable) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                window_end_c = (gate_cnt == GATE_LAST);
                run_c        = enable & ~window_end_c;
                if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            settle_cnt <= '0;
        end else if (!settled_c) begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
        end
    end

    // Counters restart on the closing cycle itself, so windows abut with no gap.
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            freq_valid <= window_end_c;
            busy       <= (state_nxt == MEASURE);
            if (window_end_c) begin
                freq_out <= edge_cnt_inc_c;
                overflow <= ovf | sat_edge_c;
            end
            if (run_c) begin
                gate_cnt <= gate_cnt + GATE_W'(1);
                edge_cnt <= edge_cnt_inc_c;
                ovf      <= ovf | sat_edge_c;
            end else begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf      <= 1'b0;
            end
        end
    end

endmodule
